// File: rtl/dmem_access_unit.sv
// Data-memory access unit: one load/store at a time over mem_r/mem_w/mem_done,
// with sub-word load extraction and read-modify-write for byte/half stores.
module dmem_access_unit #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 32,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDRSIZE-1:0] req_addr,
   input  logic [WIDTH-1:0]    req_wdata,
   output logic                resp_valid,
   output logic [WIDTH-1:0]    resp_rdata,
   output logic                resp_err,
   output logic                stall,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   output logic                mem_r,
   output logic                mem_w,
   input  logic [WIDTH-1:0]    mem_rdata,
   input  logic                mem_done
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, READ, WRITE, RMW_RD, RMW_GAP, RMW_WR, RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [ADDRSIZE-1:0] addr_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic                err_q;
   logic [15:0]         wdata_q;
   logic [WIDTH-1:0]    word_q;
   logic [WIDTH-1:0]    rdata_q;
   logic [WIDTH-1:0]    load_val;
   logic [WIDTH-1:0]    merged;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic                misalign;
   logic                strobe;
   logic                tmo;
   logic                accept;

   assign accept = (state_q == IDLE) && req_valid;
   assign strobe = state_q inside {READ, WRITE, RMW_RD, RMW_WR};
   assign tmo    = strobe && !mem_done &&
                   (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      misalign = 1'b0;
      unique case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misalign)
                  state_d = RESP;
               else if (!req_we)
                  state_d = READ;
               else if (req_size == 2'b10)
                  state_d = WRITE;
               else
                  state_d = RMW_RD;
            end
         end
         READ, WRITE, RMW_WR: begin
            if (mem_done || tmo)
               state_d = RESP;
         end
         RMW_RD: begin
            if (mem_done)
               state_d = RMW_GAP;
            else if (tmo)
               state_d = RESP;
         end
         RMW_GAP: state_d = RMW_WR;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Little-endian lane select drives both load extension and the RMW merge
   always_comb begin
      byte_v   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_rdata;
      merged   = mem_rdata;
      unique case (size_q)
         2'b00: begin
            load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_val = {{16{~uns_q & half_v[15]}}, half_v};
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (strobe)
            cnt_q <= cnt_q + CW'(1);
         if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            word_q  <= req_wdata;
            rdata_q <= '0;
            err_q   <= misalign;
         end
         if (state_q == READ && mem_done)
            rdata_q <= load_val;
         if (state_q == RMW_RD && mem_done)
            word_q <= merged;
         if (tmo)
            err_q <= 1'b1;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = rdata_q;
   assign stall      = !(state_q inside {IDLE, RESP});
   assign mem_addr   = {addr_q[ADDRSIZE-1:2], 2'b00};
   assign mem_wdata  = word_q;
   assign mem_r      = (state_q == READ) || (state_q == RMW_RD);
   assign mem_w      = (state_q == WRITE) || (state_q == RMW_WR);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: word memory model with wait states,
// response scoreboard and strobe monitor.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] mem_rdata;
   logic        mem_done;

   always #5 clk = ~clk;

   dmem_access_unit #(
      .WIDTH(32), .ADDRSIZE(32), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .stall(stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_r(mem_r), .mem_w(mem_w),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory model
   logic [31:0] mem [64];
   logic        done_q = 1'b0;
   logic        spur = 1'b0;
   logic        hang = 1'b0;
   logic        zw = 1'b0;
   logic [31:0] rd_q = '0;
   int          wcnt = 0;
   int          dly = 0;
   logic [5:0]  idx;

   assign idx       = mem_addr[7:2];
   assign mem_done  = zw ? (mem_r | mem_w) : (done_q | spur);
   assign mem_rdata = zw ? mem[idx] : rd_q;

   always @(posedge clk) begin
      done_q <= 1'b0;
      if (zw) begin
         if (mem_w) mem[idx] <= mem_wdata;
      end else if ((mem_r || mem_w) && !hang && !done_q) begin
         if (wcnt >= dly) begin
            done_q <= 1'b1;
            wcnt   <= 0;
            rd_q   <= mem[idx];
            if (mem_w) mem[idx] <= mem_wdata;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (!(mem_r || mem_w)) begin
         wcnt <= 0;
      end
   end

   // cycle counter and monitors
   int          cyc = 0;
   int          resp_cyc = 0;
   int          resp_cnt = 0;
   int          r_cnt = 0;
   int          w_cnt = 0;
   int          idle_run = 0;
   int          gap_w = -1;
   logic        prev_w = 1'b0;
   logic [31:0] w_addr = '0;
   logic [31:0] w_data = '0;
   logic [32:0] sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_r) r_cnt++;
      if (mem_w) begin
         w_cnt++;
         w_addr = mem_addr;
         w_data = mem_wdata;
      end
      if (mem_w && !prev_w) gap_w = idle_run;
      if (mem_r || mem_w) idle_run = 0;
      else idle_run++;
      prev_w = mem_w;
      chk("strobe_excl", {63'd0, mem_r & mem_w}, 64'd0);
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (resp_valid) begin
         resp_cnt++;
         resp_cyc = cyc;
         chk("stall_at_resp", {63'd0, stall}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_err", {63'd0, resp_err}, {63'd0, e[32]});
            chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic clr();
      r_cnt = 0;
      w_cnt = 0;
      gap_w = -1;
   endtask

   task automatic do_req(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err,
                         input logic [31:0] e_rd, input int e_lat);
      int n;
      int acc;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      clr();
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      sb.push_back({e_err, e_rd});
      @(posedge clk);
      #1;
      acc          = cyc;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      chk("ready_busy", {63'd0, req_ready}, 64'd0);
      chk("stall_busy", {63'd0, stall}, {63'd0, e_lat > 0});
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("resp_seen", {63'd0, sb.size() == 0}, 64'd1);
      chk("latency", 64'(resp_cyc - acc), 64'(e_lat));
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[8] = 32'h11223344;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_outs", {57'd0, resp_valid, resp_err, stall, mem_r, mem_w,
                       |resp_rdata, |mem_addr}, 64'd0);
      chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
      rst = 1'b1;
      clr();
      repeat (5) @(negedge clk);
      chk("idle_strobes", 64'(r_cnt + w_cnt), 64'd0);
      chk("idle_ready", {63'd0, req_ready}, 64'd1);

      // word store then loads with various wait states
      do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
      chk("sw_wcycles", 64'(w_cnt), 64'd2);
      chk("sw_addr", {32'd0, w_addr}, 64'h10);
      chk("sw_mem", {32'd0, mem[4]}, 64'hDEADBEEF);
      dly = 3;
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 5);
      chk("lw_rcycles", 64'(r_cnt), 64'd5);
      dly = 0;
      zw = 1'b1;
      do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1);
      zw = 1'b0;

      // byte store read-modify-write and sub-word loads
      do_req(1, 2'b00, 0, 32'h22, 32'h123456AA, 0, 32'h0, 5);
      chk("sb_mem", {32'd0, mem[8]}, 64'h11AA3344);
      chk("sb_wdata", {32'd0, w_data}, 64'h11AA3344);
      chk("sb_gap", 64'(gap_w), 64'd1);
      chk("sb_rcycles", 64'(r_cnt), 64'd2);
      chk("sb_wcycles", 64'(w_cnt), 64'd2);
      do_req(0, 2'b00, 0, 32'h22, 32'h0, 0, 32'hFFFFFFAA, 2);
      do_req(0, 2'b00, 1, 32'h22, 32'h0, 0, 32'h000000AA, 2);
      do_req(0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h00003344, 2);
      do_req(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h000011AA, 2);
      do_req(0, 2'b00, 0, 32'h23, 32'h0, 0, 32'h00000011, 2);
      do_req(1, 2'b01, 0, 32'h22, 32'hFFFF8001, 0, 32'h0, 5);
      chk("sh_mem", {32'd0, mem[8]}, 64'h80013344);
      do_req(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF8001, 2);
      do_req(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h00008001, 2);

      // alignment and illegal size errors
      do_req(0, 2'b01, 0, 32'h21, 32'h0, 1, 32'h0, 0);
      chk("lh_mis_strobes", 64'(r_cnt + w_cnt), 64'd0);
      do_req(1, 2'b10, 0, 32'h06, 32'hCAFEF00D, 1, 32'h0, 0);
      chk("sw_mis_strobes", 64'(r_cnt + w_cnt), 64'd0);
      do_req(0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 0);
      chk("size11_strobes", 64'(r_cnt + w_cnt), 64'd0);

      // timeout, then spurious done in idle
      hang = 1'b1;
      do_req(0, 2'b10, 0, 32'h00, 32'h0, 1, 32'h0, 64);
      chk("tmo_rcycles", 64'(r_cnt), 64'd64);
      hang = 1'b0;
      chk("tmo_ready", {63'd0, req_ready}, 64'd1);
      rc = resp_cnt;
      clr();
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      repeat (5) @(negedge clk);
      chk("spur_no_resp", 64'(resp_cnt), 64'(rc));
      chk("spur_strobes", 64'(r_cnt + w_cnt), 64'd0);

      // reset during the read half of a half-word RMW
      hang = 1'b1;
      clr();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b01;
      req_addr  = 32'h20;
      req_wdata = 32'h00005555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rmw_rd_active", {63'd0, mem_r}, 64'd1);
      rc = resp_cnt;
      rst = 1'b0;
      #1;
      chk("rst_mid_strobes", {62'd0, mem_r, mem_w}, 64'd0);
      chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      rst  = 1'b1;
      hang = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_mid_nowrite", 64'(w_cnt), 64'd0);
      chk("rst_mid_noresp", 64'(resp_cnt), 64'(rc));
      chk("rst_mid_mem", {32'd0, mem[8]}, 64'h80013344);
      do_req(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h80013344, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
